// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch and decode stages.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Major opcodes already used by decode.
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;

    function automatic logic [6:0] opcode_of(input logic [31:0] word);
        return word[6:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from storage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited sequential requests, in-order
// responses buffered with their PC, stale responses dropped after a redirect.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int                    ADDRESS_BITS    = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC      = '0,
    parameter int                    FIFO_DEPTH      = 2,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req_valid,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_rsp_valid,
    input  logic [31:0]             imem_rsp_data,
    output logic                    instr_valid,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [31:0]             instr,
    input  logic                    decode_ready,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC
);

    localparam int OW  = $clog2(MAX_OUTSTANDING+1);
    localparam int FCW = $clog2(FIFO_DEPTH+1);
    localparam int EW  = ADDRESS_BITS + 32;

    logic [ADDRESS_BITS-1:0] r_req_pc;
    logic [ADDRESS_BITS-1:0] r_rsp_pc;
    logic [OW-1:0]           r_outstanding;
    logic [OW-1:0]           r_drop_count;

    logic [FCW-1:0]          w_fifo_count;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    logic [EW-1:0]           w_fifo_dout;
    logic                    w_pop;
    logic                    w_redirect;
    logic                    w_rsp_fire;
    logic                    w_req_fire;
    logic                    w_push;
    logic                    w_credit_ok;
    logic [OW-1:0]           w_out_after_rsp;
    logic [ADDRESS_BITS-1:0] w_target_aligned;

    assign w_pop            = instr_valid && decode_ready;
    assign w_redirect       = w_pop && next_PC_select;
    assign w_target_aligned = target_PC & ~(ADDRESS_BITS'(3));

    // Outstanding counts requests whose response may still fill the FIFO, so
    // a response can never arrive to a full buffer.
    assign w_credit_ok = (int'(r_outstanding) < MAX_OUTSTANDING) &&
                         (int'(r_outstanding) + int'(w_fifo_count) < FIFO_DEPTH);

    assign imem_req_valid = reset && !w_redirect && w_credit_ok;
    assign imem_req_addr  = r_req_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_fire      = imem_rsp_valid && reset && (r_outstanding != '0);
    assign w_push          = w_rsp_fire && (r_drop_count == '0) && !w_redirect;
    assign w_out_after_rsp = r_outstanding - OW'(w_rsp_fire);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_req_pc      <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_count  <= '0;
        end else begin
            r_outstanding <= w_out_after_rsp + OW'(w_req_fire);
            if (w_redirect) begin
                r_req_pc     <= w_target_aligned;
                r_rsp_pc     <= w_target_aligned;
                r_drop_count <= w_out_after_rsp;
            end else begin
                if (w_req_fire) begin
                    r_req_pc <= r_req_pc + ADDRESS_BITS'(4);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + ADDRESS_BITS'(4);
                end
                if (w_rsp_fire && (r_drop_count != '0)) begin
                    r_drop_count <= r_drop_count - 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_redirect),
        .din   ({r_rsp_pc, imem_rsp_data}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign instr_valid = !w_fifo_empty;
    assign PC          = w_fifo_empty ? r_rsp_pc : w_fifo_dout[EW-1:32];
    assign instr       = w_fifo_empty ? NOP_INSTR : w_fifo_dout[31:0];

    a_drop_le_outstanding: assert property (@(posedge clock) disable iff (!reset)
        r_drop_count <= r_outstanding);

    a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset)
        !(w_push && w_fifo_full && !w_pop));

    a_empty_shows_nop: assert property (@(posedge clock) disable iff (!reset)
        !instr_valid |-> (opcode_of(instr) == I_TYPE));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: random memory/decode behaviour, expected
// instruction stream derived from the fetch rules (sequential PCs, redirects).
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int          AB    = 16;
    localparam logic [15:0] RPC   = 16'h0000;
    localparam int          DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [15:0] PC;
    logic [31:0] instr;
    logic        decode_ready;
    logic        next_PC_select;
    logic [15:0] target_PC;

    always #5 clock = ~clock;

    fetch_queue #(
        .ADDRESS_BITS    (AB),
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .PC             (PC),
        .instr          (instr),
        .decode_ready   (decode_ready),
        .next_PC_select (next_PC_select),
        .target_PC      (target_PC)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int ready_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int dr_pct = 100;
    int redir_pct = 0;
    bit force_redir = 1'b0;
    bit force_with_rsp = 1'b0;
    logic [15:0] force_target = '0;
    int redir_cyc = -1;
    logic redir_req_valid = 1'b1;

    typedef struct {int due; logic [31:0] data;} mem_t;
    typedef struct {int c; logic [15:0] a;} acc_t;
    typedef struct {logic [15:0] pc; logic [31:0] data;} exp_t;
    mem_t mem_q[$];
    acc_t acc_log[$];
    int   cons_log[$];
    exp_t exp_q[$];
    logic [15:0] exp_next = RPC;
    int last_due = 0;
    bit was_reset = 1'b1;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory + decode environment: drives inputs on the falling edge and
    // records accepted requests just before the rising edge.
    initial begin : env
        int lat;
        int due;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        decode_ready   = 1'b0;
        next_PC_select = 1'b0;
        target_PC      = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset && was_reset) begin
                mem_q.delete();
                last_due = cyc;
            end
            was_reset = !reset;
            imem_req_ready = int'($urandom_range(0, 99)) < ready_pct;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_q[0].data;
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            decode_ready   = int'($urandom_range(0, 99)) < dr_pct;
            next_PC_select = int'($urandom_range(0, 99)) < redir_pct;
            target_PC      = 16'($urandom);
            if (force_redir && reset && instr_valid && (!force_with_rsp || imem_rsp_valid)) begin
                decode_ready   = 1'b1;
                next_PC_select = 1'b1;
                target_PC      = force_target;
                force_redir    = 1'b0;
                redir_cyc      = cyc;
            end
            #2;
            if (redir_cyc == cyc) redir_req_valid = imem_req_valid;
            if (reset && imem_req_valid && imem_req_ready) begin
                lat = int'($urandom_range(lat_min, lat_max));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{due, mem_word(imem_req_addr)});
                acc_log.push_back('{cyc, imem_req_addr});
            end
        end
    end

    // Monitor: every consumed head must be the next PC of the current path.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (!reset) begin
                exp_q.delete();
                exp_next = RPC;
            end else if (!instr_valid) begin
                chk("empty_nop", instr, NOP_INSTR);
            end else if (decode_ready) begin
                while (exp_q.size() < 4) begin
                    exp_q.push_back('{exp_next, mem_word(exp_next)});
                    exp_next = exp_next + 16'd4;
                end
                e = exp_q.pop_front();
                chk("head_pc", 32'(PC), 32'(e.pc));
                chk("head_instr", instr, e.data);
                cons_log.push_back(cyc);
                if (next_PC_select) begin
                    exp_q.delete();
                    exp_next = target_PC & 16'hFFFC;
                end
            end
        end
    end

    initial begin : main
        int n0;
        int c0;
        int k;
        bit found;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_pc", 32'(PC), 32'(RPC));
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        reset = 1'b1;

        // Latency 1, decode always ready.
        repeat (30) @(posedge clock);
        #1;
        chk("startup_log_size", 32'(acc_log.size() >= 3 && cons_log.size() >= 1), 1);
        if (acc_log.size() >= 3 && cons_log.size() >= 1) begin
            chk("first_req_addr", 32'(acc_log[0].a), 32'h0000);
            chk("second_req_addr", 32'(acc_log[1].a), 32'h0004);
            chk("third_req_addr", 32'(acc_log[2].a), 32'h0008);
            chk("first_valid_latency", 32'(cons_log[0] - acc_log[0].c), 2);
        end

        // Decode stall.
        dr_pct = 0;
        n0 = acc_log.size();
        repeat (10) @(posedge clock);
        #1;
        chk("stall_accepts_le_depth", 32'((acc_log.size() - n0) <= DEPTH), 1);
        chk("stall_req_valid_low", 32'(imem_req_valid), 0);
        chk("stall_head_valid", 32'(instr_valid), 1);
        c0 = cons_log.size();
        dr_pct = 100;
        repeat (10) @(posedge clock);
        #1;
        chk("stall_release_progress", 32'(cons_log.size() >= c0 + 2), 1);

        // Directed redirect to an unaligned target with requests in flight.
        lat_min = 3;
        lat_max = 3;
        repeat (10) @(posedge clock);
        #1;
        force_target = 16'h0102;
        force_redir = 1'b1;
        for (k = 0; k < 100 && force_redir; k++) @(posedge clock);
        #1;
        chk("redir_fired", 32'(force_redir), 0);
        chk("redir_req_valid_low", 32'(redir_req_valid), 0);
        found = 1'b0;
        for (k = 0; k < 100 && !found; k++) begin
            @(posedge clock);
            #1;
            foreach (acc_log[i]) if (!found && acc_log[i].c > redir_cyc) begin
                found = 1'b1;
                chk("redir_next_addr", 32'(acc_log[i].a), 32'h0100);
            end
        end
        chk("redir_new_request_seen", 32'(found), 1);

        // Redirect coinciding with a response.
        lat_min = 1;
        lat_max = 2;
        force_with_rsp = 1'b1;
        force_target = 16'h4446;
        force_redir = 1'b1;
        for (k = 0; k < 300 && force_redir; k++) @(posedge clock);
        #1;
        chk("redir_rsp_fired", 32'(force_redir), 0);
        force_with_rsp = 1'b0;
        force_redir = 1'b0;
        c0 = cons_log.size();
        repeat (30) @(posedge clock);
        #1;
        chk("redir_rsp_progress", 32'(cons_log.size() > c0), 1);

        // Random traffic.
        ready_pct = 50;
        lat_min = 1;
        lat_max = 4;
        dr_pct = 70;
        redir_pct = 5;
        c0 = cons_log.size();
        repeat (3000) @(posedge clock);
        #1;
        chk("random_progress", 32'(cons_log.size() > c0 + 50), 1);

        // Reset with requests outstanding.
        redir_pct = 0;
        dr_pct = 100;
        ready_pct = 100;
        lat_min = 4;
        lat_max = 4;
        for (k = 0; k < 100 && mem_q.size() < 2; k++) @(posedge clock);
        #1;
        chk("pre_reset_outstanding", 32'(mem_q.size() >= 2), 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_instr_valid", 32'(instr_valid), 0);
        chk("midrst_pc", 32'(PC), 32'(RPC));
        chk("midrst_req_valid", 32'(imem_req_valid), 0);
        repeat (2) @(posedge clock);
        #1;
        n0 = acc_log.size();
        reset = 1'b1;
        for (k = 0; k < 100 && acc_log.size() == n0; k++) @(posedge clock);
        #1;
        chk("restart_req_seen", 32'(acc_log.size() > n0), 1);
        if (acc_log.size() > n0) chk("restart_addr", 32'(acc_log[n0].a), 32'(RPC));
        c0 = cons_log.size();
        repeat (50) @(posedge clock);
        #1;
        chk("restart_progress", 32'(cons_log.size() > c0), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
